pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage MIPS pipeline. It generates stall, flush and forwarding controls for the F/D, D/E, E/M and M/W registers. It handles load-use and branch RAW hazards, and it runs a state machine that holds the front end during multi-cycle multiply/divide and drains the pipeline for syscalls. Its `flush_e` output drives the D/E register clear input.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/hazard_forward_sel.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option: HAZARD_FORWARD_EN selects forwarding vs. stall-only hazard handling.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMulDiv   = 2'd1,
    StSysDrain = 2'd2,
    StSysWait  = 2'd3
  } hazard_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a stage writing dst with enable we produces the value src needs.
  function automatic logic reg_match(logic [4:0] src, logic [4:0] dst, logic we);
    return we && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_forward_sel.sv
// Per-operand forwarding select: picks M over W, never forwards register 0.
module hazard_forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_match(src, write_reg_m, reg_write_m)) begin
      sel = FWD_M;
    end else if (reg_match(src, write_reg_w, reg_write_w)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and mul/div/syscall sequencing control for the 5-stage pipeline.
// Build option: define HAZARD_FORWARD_EN to enable forwarding; otherwise RAW hazards stall.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_e,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  input  logic       mem_to_reg_e,
  input  logic       mem_to_reg_m,
  input  logic       branch_d,
  input  logic       pc_src_d,
  input  logic       muldiv_start_e,
  input  logic       syscall_e,
  input  logic       sys_ack,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic [1:0] forward_a_e,
  output logic [1:0] forward_b_e,
  output logic       forward_a_d,
  output logic       forward_b_d,
  output logic       sys_req,
  output logic       busy
);

  hazard_state_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          hazard_run;

`ifdef HAZARD_FORWARD_EN
  logic       lw_stall;
  logic       br_stall;
  logic [1:0] sel_a_e, sel_b_e, sel_a_d, sel_b_d;
  logic       unused_fwd_d;

  always_comb begin
    lw_stall = mem_to_reg_e && (rt_e != REG_ZERO) && ((rt_e == rs_d) || (rt_e == rt_d));
    br_stall = branch_d &&
               (reg_match(rs_d, write_reg_e, reg_write_e) ||
                reg_match(rs_d, write_reg_m, mem_to_reg_m) ||
                reg_match(rt_d, write_reg_e, reg_write_e) ||
                reg_match(rt_d, write_reg_m, mem_to_reg_m));
    hazard_run = lw_stall || br_stall;
  end

  hazard_forward_sel u_fwd_a_e (
    .src         (rs_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (write_reg_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_a_e)
  );

  hazard_forward_sel u_fwd_b_e (
    .src         (rt_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (write_reg_w),
    .reg_write_w (reg_write_w),
    .sel         (sel_b_e)
  );

  // Decode comparator only forwards from M, so the W match is masked off.
  hazard_forward_sel u_fwd_a_d (
    .src         (rs_d),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (REG_ZERO),
    .reg_write_w (1'b0),
    .sel         (sel_a_d)
  );

  hazard_forward_sel u_fwd_b_d (
    .src         (rt_d),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (REG_ZERO),
    .reg_write_w (1'b0),
    .sel         (sel_b_d)
  );

  assign unused_fwd_d = ^{sel_a_d[0], sel_b_d[0]};

  assign forward_a_e = rst_n ? sel_a_e : FWD_RF;
  assign forward_b_e = rst_n ? sel_b_e : FWD_RF;
  assign forward_a_d = rst_n && sel_a_d[1];
  assign forward_b_d = rst_n && sel_b_d[1];
`else
  logic unused_inputs;

  // W writes land in the first half-cycle, so only E and M producers stall.
  always_comb begin
    hazard_run = reg_match(rs_d, write_reg_e, reg_write_e) ||
                 reg_match(rs_d, write_reg_m, reg_write_m) ||
                 reg_match(rt_d, write_reg_e, reg_write_e) ||
                 reg_match(rt_d, write_reg_m, reg_write_m);
  end

  assign unused_inputs = ^{rs_e, rt_e, write_reg_w, reg_write_w, mem_to_reg_e, mem_to_reg_m,
                           branch_d};

  assign forward_a_e = FWD_RF;
  assign forward_b_e = FWD_RF;
  assign forward_a_d = 1'b0;
  assign forward_b_d = 1'b0;
`endif

  always_comb begin
    stall_f = 1'b0;
    flush_d = 1'b0;
    if (rst_n) begin
      if (state_q == StRun) begin
        stall_f = hazard_run;
        flush_d = pc_src_d && !hazard_run;
      end else begin
        stall_f = 1'b1;
      end
    end
  end

  assign stall_d = stall_f;
  assign flush_e = stall_f;
  assign sys_req = (state_q == StSysWait);
  assign busy    = (state_q != StRun);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (syscall_e) begin
          state_d = StSysDrain;
          cnt_d   = 4'd1;
        end else if (muldiv_start_e) begin
          state_d = StMulDiv;
          cnt_d   = 4'(MULDIV_LAT - 2);
        end
      end
      StMulDiv: begin
        if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSysDrain: begin
        if (cnt_q == 4'd0) begin
          state_d = StSysWait;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSysWait: begin
        if (sys_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed cases plus random stimulus
// compared against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned Lat = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, pc_src_d, muldiv_start_e, syscall_e, sys_ack;
  logic       stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d, sys_req, busy;
  logic [1:0] forward_a_e, forward_b_e;

  int total = 0;
  int bad = 0;

  // Reference model: remaining busy cycles of each long operation.
  int md_rem = 0;
  int drain_rem = 0;
  bit wait_sys = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(Lat)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .rs_e           (rs_e),
    .rt_e           (rt_e),
    .write_reg_e    (write_reg_e),
    .write_reg_m    (write_reg_m),
    .write_reg_w    (write_reg_w),
    .reg_write_e    (reg_write_e),
    .reg_write_m    (reg_write_m),
    .reg_write_w    (reg_write_w),
    .mem_to_reg_e   (mem_to_reg_e),
    .mem_to_reg_m   (mem_to_reg_m),
    .branch_d       (branch_d),
    .pc_src_d       (pc_src_d),
    .muldiv_start_e (muldiv_start_e),
    .syscall_e      (syscall_e),
    .sys_ack        (sys_ack),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .forward_a_e    (forward_a_e),
    .forward_b_e    (forward_b_e),
    .forward_a_d    (forward_a_d),
    .forward_b_d    (forward_b_d),
    .sys_req        (sys_req),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] s, input logic [4:0] d, input logic we);
    return we && (s != 5'd0) && (s == d);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] s);
`ifdef HAZARD_FORWARD_EN
    if (hit(s, write_reg_m, reg_write_m)) return 2'b10;
    if (hit(s, write_reg_w, reg_write_w)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic bit fwd_d(input logic [4:0] s);
`ifdef HAZARD_FORWARD_EN
    return hit(s, write_reg_m, reg_write_m);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    bit m_busy, haz, exp_stall, exp_flush_d;
    logic [4:0] srcs [2];
    srcs[0] = rs_d;
    srcs[1] = rt_d;
    m_busy = (md_rem > 0) || (drain_rem > 0) || wait_sys;
    haz = 1'b0;
`ifdef HAZARD_FORWARD_EN
    if (mem_to_reg_e && rt_e != 5'd0 && (rt_e == rs_d || rt_e == rt_d)) haz = 1'b1;
    foreach (srcs[i])
      if (branch_d && (hit(srcs[i], write_reg_e, reg_write_e) ||
                       hit(srcs[i], write_reg_m, mem_to_reg_m))) haz = 1'b1;
`else
    foreach (srcs[i])
      if (hit(srcs[i], write_reg_e, reg_write_e) || hit(srcs[i], write_reg_m, reg_write_m))
        haz = 1'b1;
`endif
    exp_stall   = rst_n && (m_busy || haz);
    exp_flush_d = rst_n && !m_busy && !haz && pc_src_d;
    chk("stall_f", 4'(stall_f), 4'(exp_stall));
    chk("stall_d", 4'(stall_d), 4'(exp_stall));
    chk("flush_e", 4'(flush_e), 4'(exp_stall));
    chk("flush_d", 4'(flush_d), 4'(exp_flush_d));
    chk("busy", 4'(busy), 4'(rst_n && m_busy));
    chk("sys_req", 4'(sys_req), 4'(rst_n && wait_sys));
    chk("forward_a_e", 4'(forward_a_e), rst_n ? 4'(fwd_e(rs_e)) : 4'd0);
    chk("forward_b_e", 4'(forward_b_e), rst_n ? 4'(fwd_e(rt_e)) : 4'd0);
    chk("forward_a_d", 4'(forward_a_d), 4'(rst_n && fwd_d(rs_d)));
    chk("forward_b_d", 4'(forward_b_d), 4'(rst_n && fwd_d(rt_d)));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      md_rem = 0; drain_rem = 0; wait_sys = 1'b0;
    end else if (md_rem > 0) begin
      md_rem--;
    end else if (drain_rem > 0) begin
      drain_rem--;
      if (drain_rem == 0) wait_sys = 1'b1;
    end else if (wait_sys) begin
      if (sys_ack) wait_sys = 1'b0;
    end else if (syscall_e) begin
      drain_rem = 2;
    end else if (muldiv_start_e) begin
      md_rem = Lat - 1;
    end
  endtask

  // Inputs are set at a negedge; outputs are checked 1 time unit later.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, pc_src_d, muldiv_start_e, syscall_e, sys_ack} = '0;
  endtask

  task automatic random_inputs();
    rs_d = 5'($urandom_range(0, 3));        rt_d = 5'($urandom_range(0, 3));
    rs_e = 5'($urandom_range(0, 3));        rt_e = 5'($urandom_range(0, 3));
    write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
    write_reg_w = 5'($urandom_range(0, 3));
    reg_write_e = 1'($urandom_range(0, 1)); reg_write_m = 1'($urandom_range(0, 1));
    reg_write_w = 1'($urandom_range(0, 1)); mem_to_reg_e = 1'($urandom_range(0, 1));
    mem_to_reg_m = 1'($urandom_range(0, 1)); branch_d = 1'($urandom_range(0, 1));
    pc_src_d = 1'($urandom_range(0, 1));
    muldiv_start_e = ($urandom_range(0, 7) == 0);
    syscall_e = ($urandom_range(0, 9) == 0);
    sys_ack = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    // Reset state, with a hazard present on the inputs.
    rs_d = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1; pc_src_d = 1'b1;
    step();
    rst_n = 1'b1;
    idle_inputs();
    step();

`ifdef HAZARD_FORWARD_EN
    rs_e = 5'd5; write_reg_m = 5'd5; reg_write_m = 1'b1; write_reg_w = 5'd5; reg_write_w = 1'b1;
    #1 chk("fwd_m_priority", 4'(forward_a_e), 4'b0010);
    step();
    rs_e = 5'd0;
    #1 chk("fwd_reg_zero", 4'(forward_a_e), 4'b0000);
    step();
    idle_inputs();
`else
    rs_d = 5'd3; write_reg_m = 5'd3; reg_write_m = 1'b1;
    #1 chk("nofwd_stall", 4'(stall_f), 4'd1);
    chk("nofwd_fwd", 4'(forward_a_d), 4'd0);
    step();
    idle_inputs();
`endif

    // Load-use stall suppresses the branch flush for one cycle.
    mem_to_reg_e = 1'b1; rt_e = 5'd8; rs_d = 5'd8; write_reg_e = 5'd8; reg_write_e = 1'b1;
    pc_src_d = 1'b1;
    #1 chk("lu_stall", 4'(stall_f), 4'd1);
    chk("lu_flush_d", 4'(flush_d), 4'd0);
    step();
    idle_inputs();
    #1 chk("lu_release", 4'(stall_f), 4'd0);
    step();

    // Mul/div: LAT-1 stalled cycles after the start is sampled.
    muldiv_start_e = 1'b1;
    step();
    muldiv_start_e = 1'b0;
    for (int c = 0; c < int'(Lat) + 1; c++) begin
      #1 chk("md_busy", 4'(busy), 4'(c < int'(Lat) - 1));
      chk("md_stall", 4'(stall_f), 4'(c < int'(Lat) - 1));
      step();
    end

    // Syscall: request 2 cycles after sampling, ack at cycle 6 drops it at cycle 7.
    syscall_e = 1'b1;
    step();
    syscall_e = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 6) sys_ack = 1'b1;
      #1 chk("sys_req_seq", 4'(sys_req), 4'(c >= 2));
      step();
    end
    sys_ack = 1'b0;
    #1 chk("sys_done_req", 4'(sys_req), 4'd0);
    chk("sys_done_stall", 4'(stall_f), 4'd0);
    step();

    // Reset while waiting on the syscall handler.
    syscall_e = 1'b1;
    step();
    syscall_e = 1'b0;
    repeat (3) step();
    #1 chk("pre_rst_req", 4'(sys_req), 4'd1);
    rst_n = 1'b0;
    rs_d = 5'd2; write_reg_e = 5'd2; reg_write_e = 1'b1; pc_src_d = 1'b1;
    #1 chk("rst_req", 4'(sys_req), 4'd0);
    chk("rst_busy", 4'(busy), 4'd0);
    chk("rst_stall", 4'(stall_f), 4'd0);
    step();
    rst_n = 1'b1;
    idle_inputs();
    #1 chk("post_rst_busy", 4'(busy), 4'd0);
    step();
    step();

    for (int n = 0; n < 500; n++) begin
      random_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
